// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer.
// Holds the counter-width helper and default parameter values used by
// debounce_channel and debounce_multi.
package debounce_pkg;

    localparam int unsigned DEFAULT_COUNTER_LIMIT = 250000;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

    // Smallest w such that 2**w >= value (ceil log2).
    function automatic int unsigned clog2(input logic [32:0] value);
        int unsigned w;
        logic [33:0] span;
        w    = 0;
        span = 34'd1;
        while (span < 34'(value)) begin
            span = span << 1;
            w    = w + 1;
        end
        return w;
    endfunction

    // Qualification counter width: enough bits to hold 0..limit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        w = clog2(33'(limit) + 33'd1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: synchroniser chain, qualification counter,
// debounced state and registered rise/fall pulses.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_switch       raw asynchronous switch level
//   o_switch       debounced level
//   o_rise/o_fall  one-cycle pulse after o_switch goes 0->1 / 1->0
//   o_event_c      combinational: o_switch will change at the next edge
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned COUNTER_LIMIT = DEFAULT_COUNTER_LIMIT,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall,
    output logic o_event_c
);

    localparam int unsigned        CNT_W   = cnt_width(COUNTER_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(COUNTER_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_lvl;

    // Shift raw level into the synchroniser; last stage is the usable level.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_switch};
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Qualification: any agreement clears the count; a full run of
    // COUNTER_LIMIT mismatching cycles commits the new level.
    always_comb begin
        cnt_d   = '0;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_lvl != state_q) begin
            if (cnt_q == CNT_MAX) begin
                state_d = sync_lvl;
                rise_d  = sync_lvl;
                fall_d  = ~sync_lvl;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            cnt_q   <= '0;
            state_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_switch  = state_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_event_c = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: NUM_CH independent debounce_channel
// instances plus a registered any-event pulse.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_switch       raw asynchronous switch levels, one bit per channel
//   o_switch       debounced levels
//   o_rise/o_fall  per-channel one-cycle edge pulses
//   o_any_event    one-cycle pulse concurrent with any rise/fall pulse
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned COUNTER_LIMIT = DEFAULT_COUNTER_LIMIT,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_switch,
    output logic [NUM_CH-1:0] o_switch,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic              o_any_event
);

    // Reject unsupported parameterisations at elaboration.
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $fatal(1, "debounce_multi: NUM_CH must be 1..32");
    end
    if (COUNTER_LIMIT < 1) begin : g_bad_limit
        $fatal(1, "debounce_multi: COUNTER_LIMIT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "debounce_multi: SYNC_STAGES must be >= 2");
    end

    logic [NUM_CH-1:0] event_c;
    logic              any_event_q, any_event_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(
            .COUNTER_LIMIT (COUNTER_LIMIT),
            .SYNC_STAGES   (SYNC_STAGES),
            .INIT_LEVEL    (INIT_LEVEL)
        ) u_channel (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_switch  (i_switch[c]),
            .o_switch  (o_switch[c]),
            .o_rise    (o_rise[c]),
            .o_fall    (o_fall[c]),
            .o_event_c (event_c[c])
        );
    end

    // Registered from the channels' next-pulse terms so it lines up with them.
    assign any_event_d = |event_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= any_event_d;
        end
    end

    assign o_any_event = any_event_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi: one instance with
// COUNTER_LIMIT=4 and one with COUNTER_LIMIT=1 (both 4 channels, 2 sync stages).
module tb_debounce_multi;

    logic       clk;
    logic       rst, rst1;
    logic [3:0] sw, sw1;
    logic [3:0] o_sw, o_rise, o_fall;
    logic [3:0] o_sw1, o_rise1, o_fall1;
    logic       o_any, o_any1;

    int n_checks;
    int n_fail;

    debounce_multi #(
        .NUM_CH        (4),
        .COUNTER_LIMIT (4),
        .SYNC_STAGES   (2),
        .INIT_LEVEL    (1'b0)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_switch    (sw),
        .o_switch    (o_sw),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_any_event (o_any)
    );

    debounce_multi #(
        .NUM_CH        (4),
        .COUNTER_LIMIT (1),
        .SYNC_STAGES   (2),
        .INIT_LEVEL    (1'b0)
    ) dut1 (
        .i_clk       (clk),
        .i_rst       (rst1),
        .i_switch    (sw1),
        .o_switch    (o_sw1),
        .o_rise      (o_rise1),
        .o_fall      (o_fall1),
        .o_any_event (o_any1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_dut(input string tag, input logic [3:0] e_sw, input logic [3:0] e_rise,
                              input logic [3:0] e_fall, input logic e_any);
        check({tag, ".sw"},   32'(o_sw),   32'(e_sw));
        check({tag, ".rise"}, 32'(o_rise), 32'(e_rise));
        check({tag, ".fall"}, 32'(o_fall), 32'(e_fall));
        check({tag, ".any"},  32'(o_any),  32'(e_any));
    endtask

    task automatic expect_dut1(input string tag, input logic [3:0] e_sw, input logic [3:0] e_rise,
                               input logic [3:0] e_fall, input logic e_any);
        check({tag, ".sw"},   32'(o_sw1),   32'(e_sw));
        check({tag, ".rise"}, 32'(o_rise1), 32'(e_rise));
        check({tag, ".fall"}, 32'(o_fall1), 32'(e_fall));
        check({tag, ".any"},  32'(o_any1),  32'(e_any));
    endtask

    initial begin
        logic [3:0] pats [5];
        logic [3:0] prev, nxt;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        rst1 = 1'b1;
        sw   = 4'b0000;
        sw1  = 4'b0000;
        pats[0] = 4'b0101;
        pats[1] = 4'b0110;
        pats[2] = 4'b1111;
        pats[3] = 4'b0000;
        pats[4] = 4'b1001;

        // Reset state
        step();
        step();
        expect_dut("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_dut1("reset1", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        // ch0 held high: rises on edge 6, single pulse
        rst = 1'b0;
        sw  = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_dut("ch0_rise_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        step();
        expect_dut("ch0_rise_edge", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        step();
        expect_dut("ch0_rise_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // ch1 bouncing 3 high / 3 low never qualifies
        for (int p = 0; p < 4; p++) begin
            sw[1] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                expect_dut("bounce_hi", 4'b0001, 4'b0000, 4'b0000, 1'b0);
            end
            sw[1] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                expect_dut("bounce_lo", 4'b0001, 4'b0000, 4'b0000, 1'b0);
            end
        end

        // ch1 and ch3 raised together: concurrent rise
        sw = 4'b1011;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_dut("dual_wait", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        end
        step();
        expect_dut("dual_edge", 4'b1011, 4'b1010, 4'b0000, 1'b1);
        step();
        expect_dut("dual_after", 4'b1011, 4'b0000, 4'b0000, 1'b0);

        // ch0 dropped: falls on edge 6
        sw = 4'b1010;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_dut("ch0_fall_wait", 4'b1011, 4'b0000, 4'b0000, 1'b0);
        end
        step();
        expect_dut("ch0_fall_edge", 4'b1010, 4'b0000, 4'b0001, 1'b1);
        step();
        expect_dut("ch0_fall_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);

        // ch2 mismatch interrupted by reset after two counted cycles
        sw = 4'b1110;
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_dut("ch2_partial", 4'b1010, 4'b0000, 4'b0000, 1'b0);
        end
        rst = 1'b1;
        step();
        expect_dut("mid_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_dut("post_rst_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        step();
        expect_dut("post_rst_edge", 4'b1110, 4'b1110, 4'b0000, 1'b1);
        step();
        expect_dut("post_rst_after", 4'b1110, 4'b0000, 4'b0000, 1'b0);

        // COUNTER_LIMIT=1: output follows input with 3-edge latency
        rst1 = 1'b0;
        prev = 4'b0000;
        for (int p = 0; p < 5; p++) begin
            nxt = pats[p];
            sw1 = nxt;
            step();
            step();
            expect_dut1("lim1_hold", prev, 4'b0000, 4'b0000, 1'b0);
            step();
            expect_dut1("lim1_edge", nxt, nxt & ~prev, prev & ~nxt, |(nxt ^ prev));
            step();
            expect_dut1("lim1_after", nxt, 4'b0000, 4'b0000, 1'b0);
            prev = nxt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent switch channels, 1..32.
REQ-002 Parameter COUNTER_LIMIT, default 250000: consecutive mismatching cycles required before a channel's debounced state changes, >= 1.
REQ-003 Parameter SYNC_STAGES, default 2: metastability synchroniser depth per channel, >= 2.
REQ-004 Parameter INIT_LEVEL, default 1'b0: level loaded into every synchroniser and debounced-state flop at reset.
REQ-005 i_clk  input  1  sole clock; all flops on rising edge.
REQ-006 i_rst  input  1  reset, synchronous, active-high.
REQ-007 i_switch  input  NUM_CH  raw asynchronous switch levels, bit c = channel c.
REQ-008 o_switch  output  NUM_CH  debounced stable level per channel.
REQ-009 o_rise  output  NUM_CH  one-cycle pulse when o_switch[c] goes 0->1.
REQ-010 o_fall  output  NUM_CH  one-cycle pulse when o_switch[c] goes 1->0.
REQ-011 o_any_event  output  1  one-cycle pulse, OR of all o_rise and o_fall bits.

Function
REQ-012 Each channel shall pass i_switch[c] through a SYNC_STAGES-deep flop chain; sync[c] is the last stage.
REQ-013 Each channel shall hold a counter of width clog2(COUNTER_LIMIT+1), independent of other channels.
REQ-014 Per cycle: if sync[c] == o_switch[c], counter shall clear to 0 (any bounce back restarts qualification).
REQ-015 If sync[c] != o_switch[c] and counter < COUNTER_LIMIT-1, counter shall increment by 1.
REQ-016 If sync[c] != o_switch[c] and counter == COUNTER_LIMIT-1, o_switch[c] shall load sync[c] and counter shall clear to 0 on the same edge.
REQ-017 Counter shall never exceed COUNTER_LIMIT-1; no wrap-around.
REQ-018 A level held on i_switch[c] from before edge 0 shall appear on o_switch[c] after exactly SYNC_STAGES+COUNTER_LIMIT rising edges.
REQ-019 o_rise[c]/o_fall[c] shall be registered and asserted for exactly the one cycle immediately following the edge that updates o_switch[c]; o_rise and o_fall are never both high for the same channel.
REQ-020 o_any_event shall be registered and asserted in the same cycle as any o_rise/o_fall bit.
REQ-021 Simultaneous qualifications on several channels shall update all of them on the same edge, with all pulses concurrent.
REQ-022 With COUNTER_LIMIT = 1, o_switch[c] shall follow sync[c] with one cycle delay.

Reset
REQ-023 While i_rst is high at an edge: all synchroniser stages and o_switch shall load INIT_LEVEL on every bit, all counters 0, o_rise, o_fall, o_any_event 0.
REQ-024 Reset asserted mid-qualification shall discard partial counts; no pulse shall be generated by reset itself.
REQ-025 After i_rst deasserts, qualification restarts from zero; a held level differing from INIT_LEVEL appears after SYNC_STAGES+COUNTER_LIMIT edges.

Structure
REQ-026 Shared package debounce_pkg shall hold the counter-width function (clog2) and default constants for COUNTER_LIMIT and SYNC_STAGES.
REQ-027 One sub-module debounce_channel (synchroniser, counter, state, edge pulses for one bit) shall be instantiated NUM_CH times via generate; top level adds only o_any_event.
REQ-028 Elaboration shall fail for COUNTER_LIMIT < 1, SYNC_STAGES < 2, or NUM_CH outside 1..32.

Verification (NUM_CH=4, COUNTER_LIMIT=4, SYNC_STAGES=2, INIT_LEVEL=0)
REQ-029 Reset, then i_switch=4'b0001 held -> o_switch[0] rises after 6 edges; o_rise[0] and o_any_event high exactly one cycle; other channels unchanged.
REQ-030 i_switch[1] toggled high 3 cycles / low 3 cycles repeatedly -> o_switch[1] stays 0, no pulses.
REQ-031 i_switch[1] and [3] raised on the same cycle -> both o_switch bits rise on the same edge; o_rise=4'b1010 for one cycle.
REQ-032 After ch0 high, i_switch[0] dropped to 0 -> o_switch[0] falls after 6 edges, o_fall[0] one cycle, o_rise[0] stays 0.
REQ-033 i_rst pulsed 2 cycles after ch2 mismatch starts -> all outputs 0, no pulse; o_switch[2] rises exactly 6 edges after i_rst deasserts.
REQ-034 Re-run with COUNTER_LIMIT=1 -> o_switch tracks i_switch with 3-edge latency, one pulse per change.
